countdown_timer_dp: RTL and testbench

- Countdown datapath: the down-counting counterpart of the stopwatch datapath.
- A preset of hours, minutes and seconds is loaded, then decremented at a 1/100 s resolution while run is asserted. The block pulses done and holds expired when it reaches zero.
- Sits between the button control unit (run/clear) and the FND controller. It uses the same msec/sec/min/hour 7-bit output format, so it drives the display unchanged.

---
 rtl/countdown_timer_dp.sv | 157 +++++++++++++++
 tb/tb_countdown_timer_dp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_dp.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer_dp
// Brief    : Preset-loaded hh:mm:ss.cc countdown datapath with done/expired
//            flags, display-compatible with the stopwatch datapath.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer_dp #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [6:0] preset_sec,
    input  logic [6:0] preset_min,
    input  logic [6:0] preset_hour,
    output logic [6:0] msec,
    output logic [6:0] sec,
    output logic [6:0] min,
    output logic [6:0] hour,
    output logic       done,
    output logic       expired,
    output logic [1:0] state
);

    localparam int c_TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int c_CNT_W    = $clog2(c_TICK_DIV);

    localparam logic [c_CNT_W-1:0] c_TICK_MAX = c_CNT_W'(c_TICK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RUN     = 2'd1;
    localparam logic [1:0] c_ST_PAUSE   = 2'd2;
    localparam logic [1:0] c_ST_EXPIRED = 2'd3;

    logic [c_CNT_W-1:0] r_tick_cnt;
    logic [6:0]         r_msec, r_sec, r_min, r_hour;
    logic               r_done, r_expired;
    logic [1:0]         r_state;

    logic [6:0] w_msec_dec, w_sec_dec, w_min_dec, w_hour_dec;
    logic [6:0] w_sat_sec, w_sat_min, w_sat_hour;
    logic       w_tick, w_last, w_load_zero;

    assign w_tick = (r_tick_cnt == c_TICK_MAX);

    // One hundredth left: the next tick lands exactly on zero
    assign w_last = (r_hour == 7'd0) && (r_min == 7'd0) &&
                    (r_sec == 7'd0) && (r_msec == 7'd1);

    assign w_sat_sec  = (preset_sec  > 7'd59) ? 7'd59 : preset_sec;
    assign w_sat_min  = (preset_min  > 7'd59) ? 7'd59 : preset_min;
    assign w_sat_hour = (preset_hour > 7'd23) ? 7'd23 : preset_hour;

    assign w_load_zero = (w_sat_sec == 7'd0) && (w_sat_min == 7'd0) &&
                         (w_sat_hour == 7'd0);

    always_comb begin
        w_msec_dec = r_msec - 7'd1;
        w_sec_dec  = r_sec;
        w_min_dec  = r_min;
        w_hour_dec = r_hour;
        if (r_msec == 7'd0) begin
            w_msec_dec = 7'd99;
            if (r_sec == 7'd0) begin
                w_sec_dec = 7'd59;
                if (r_min == 7'd0) begin
                    w_min_dec  = 7'd59;
                    w_hour_dec = r_hour - 7'd1;
                end else begin
                    w_min_dec = r_min - 7'd1;
                end
            end else begin
                w_sec_dec = r_sec - 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_msec     <= 7'd0;
            r_sec      <= 7'd0;
            r_min      <= 7'd0;
            r_hour     <= 7'd0;
            r_done     <= 1'b0;
            r_expired  <= 1'b0;
            r_state    <= c_ST_IDLE;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_tick_cnt <= '0;
                r_msec     <= 7'd0;
                r_sec      <= 7'd0;
                r_min      <= 7'd0;
                r_hour     <= 7'd0;
                r_expired  <= 1'b0;
                r_state    <= c_ST_IDLE;
            end else if (load && (r_state != c_ST_RUN)) begin
                r_tick_cnt <= '0;
                r_msec     <= 7'd0;
                r_sec      <= w_sat_sec;
                r_min      <= w_sat_min;
                r_hour     <= w_sat_hour;
                r_expired  <= 1'b0;
                r_state    <= w_load_zero ? c_ST_IDLE : c_ST_PAUSE;
            end else begin
                case (r_state)
                    c_ST_PAUSE: begin
                        if (run) begin
                            r_state <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN: begin
                        // Dropping run freezes the tick phase along with the time
                        if (!run) begin
                            r_state <= c_ST_PAUSE;
                        end else if (w_tick) begin
                            r_tick_cnt <= '0;
                            if (w_last) begin
                                r_msec    <= 7'd0;
                                r_sec     <= 7'd0;
                                r_min     <= 7'd0;
                                r_hour    <= 7'd0;
                                r_done    <= 1'b1;
                                r_expired <= 1'b1;
                                r_state   <= c_ST_EXPIRED;
                            end else begin
                                r_msec <= w_msec_dec;
                                r_sec  <= w_sec_dec;
                                r_min  <= w_min_dec;
                                r_hour <= w_hour_dec;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign msec    = r_msec;
    assign sec     = r_sec;
    assign min     = r_min;
    assign hour    = r_hour;
    assign done    = r_done;
    assign expired = r_expired;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer_dp
// Brief    : Directed bench for countdown_timer_dp with a hundredths-based
//            reference model feeding a per-cycle scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_dp;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [6:0] preset_sec = 7'd0;
    logic [6:0] preset_min = 7'd0;
    logic [6:0] preset_hour = 7'd0;
    logic [6:0] msec, sec, min, hour;
    logic       done, expired;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: total time held as a single hundredths count
    int         m_t = 0;
    int         m_cnt = 0;
    logic [1:0] m_st = 2'd0;
    logic       m_done = 1'b0;
    logic       m_exp = 1'b0;

    logic [31:0] sb[$];

    countdown_timer_dp #(
        .CLK_FREQ(1000),
        .TICK_HZ (100)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .load       (load),
        .preset_sec (preset_sec),
        .preset_min (preset_min),
        .preset_hour(preset_hour),
        .msec       (msec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .done       (done),
        .expired    (expired),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic void model_step();
        int s, m, h;
        if (reset) begin
            m_t = 0; m_cnt = 0; m_st = 2'd0; m_done = 1'b0; m_exp = 1'b0;
            return;
        end
        m_done = 1'b0;
        if (clear) begin
            m_t = 0; m_cnt = 0; m_st = 2'd0; m_exp = 1'b0;
        end else if (load && m_st != 2'd1) begin
            s = sat(int'(preset_sec), 59);
            m = sat(int'(preset_min), 59);
            h = sat(int'(preset_hour), 23);
            m_t = ((h * 60 + m) * 60 + s) * 100;
            m_cnt = 0;
            m_exp = 1'b0;
            m_st = (m_t != 0) ? 2'd2 : 2'd0;
        end else if (m_st == 2'd2) begin
            if (run) m_st = 2'd1;
        end else if (m_st == 2'd1) begin
            if (!run) begin
                m_st = 2'd2;
            end else if (m_cnt == 9) begin
                m_cnt = 0;
                m_t = m_t - 1;
                if (m_t == 0) begin
                    m_st = 2'd3; m_done = 1'b1; m_exp = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    function automatic logic [31:0] pack_model();
        return {7'(m_t % 100), 7'((m_t / 100) % 60), 7'((m_t / 6000) % 60),
                7'(m_t / 360000), m_done, m_exp, m_st};
    endfunction

    function automatic logic [31:0] pack_dut();
        return {msec, sec, min, hour, done, expired, state};
    endfunction

    task automatic cycle();
        logic [31:0] exp_v, obs_v;
        model_step();
        sb.push_back(pack_model());
        @(posedge clk);
        #1;
        cyc++;
        exp_v = sb.pop_front();
        obs_v = pack_dut();
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL scoreboard cycle %0d: observed %h expected %h", cyc, obs_v, exp_v);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int cs);
        chk({tag, "_hour"}, 32'(hour), 32'(h));
        chk({tag, "_min"},  32'(min),  32'(m));
        chk({tag, "_sec"},  32'(sec),  32'(s));
        chk({tag, "_msec"}, 32'(msec), 32'(cs));
    endtask

    initial begin
        // 1: reset, then run without a load stays idle
        run_cycles(2);
        chk_time("reset", 0, 0, 0, 0);
        chk("reset_state", 32'(state), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_expired", 32'(expired), 0);
        reset = 1'b0;
        run = 1'b1;
        run_cycles(5);
        chk("idle_ignores_run", 32'(state), 0);

        // 2: two-second countdown to expiry
        run = 1'b0;
        preset_sec = 7'd2;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk_time("load2", 0, 0, 2, 0);
        chk("load2_state", 32'(state), 2);
        run = 1'b1;
        cycle();
        chk("run_state", 32'(state), 1);
        run_cycles(10);
        chk_time("first_tick", 0, 0, 1, 99);
        run_cycles(1990);
        chk_time("expire", 0, 0, 0, 0);
        chk("expire_done", 32'(done), 1);
        chk("expire_expired", 32'(expired), 1);
        chk("expire_state", 32'(state), 3);
        cycle();
        chk("done_one_cycle", 32'(done), 0);
        run_cycles(20);
        chk_time("expired_hold", 0, 0, 0, 0);
        chk("expired_hold_state", 32'(state), 3);

        // 3: hour borrow chain
        preset_sec = 7'd0;
        preset_hour = 7'd1;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_hour_state", 32'(state), 2);
        cycle();
        run_cycles(10);
        chk_time("borrow_chain", 0, 59, 59, 99);
        run_cycles(990);
        chk_time("tick100", 0, 59, 59, 0);
        run_cycles(10);
        chk_time("tick101", 0, 59, 58, 99);

        // 4: pause at tick phase 4 preserves phase
        run_cycles(4);
        run = 1'b0;
        run_cycles(50);
        chk_time("paused", 0, 59, 58, 99);
        chk("paused_state", 32'(state), 2);
        run = 1'b1;
        cycle();
        chk("resume_state", 32'(state), 1);
        run_cycles(5);
        chk("pre_phase_tick", 32'(msec), 99);
        cycle();
        chk("phase_tick", 32'(msec), 98);

        // 5: saturating load, load ignored in RUN
        run = 1'b0;
        cycle();
        preset_sec = 7'd75;
        preset_min = 7'd99;
        preset_hour = 7'd30;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk_time("saturate", 23, 59, 59, 0);
        chk("saturate_state", 32'(state), 2);
        run = 1'b1;
        cycle();
        run_cycles(3);
        preset_sec = 7'd5;
        preset_min = 7'd0;
        preset_hour = 7'd0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("load_in_run_hour", 32'(hour), 23);
        chk("load_in_run_state", 32'(state), 1);
        run_cycles(20);
        chk_time("continue", 23, 59, 58, 98);

        // 6: clear beats load; zero load stays idle with no done
        clear = 1'b1;
        load = 1'b1;
        cycle();
        clear = 1'b0;
        load = 1'b0;
        chk_time("clear_load", 0, 0, 0, 0);
        chk("clear_load_state", 32'(state), 0);
        preset_sec = 7'd0;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("zero_load_state", 32'(state), 0);
        chk("zero_load_done", 32'(done), 0);
        run_cycles(5);
        chk("zero_load_idle", 32'(state), 0);

        // 7: reset mid-count
        preset_sec = 7'd5;
        load = 1'b1;
        cycle();
        load = 1'b0;
        run_cycles(16);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk_time("mid_reset", 0, 0, 0, 0);
        chk("mid_reset_state", 32'(state), 0);
        chk("mid_reset_done", 32'(done), 0);
        run_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
